kirby_pixel_out: RTL and testbench

//  Final video stage downstream of the Kirby ray-march core. Consumes the held

---
 rtl/kirby_pixel_out.sv | 186 ++++++++++++++++++
 tb/tb_kirby_pixel_out.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kirby_pixel_out.sv
// kirby_pixel_out: final video stage behind the Kirby ray-march core.
// Applies the feature palette, luma shading, sky gradient, silhouette outline,
// 4x4 ordered dither and RGB222 quantisation. Sync and enable signals go
// through the same two register stages as the pixel data.
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset
//   h_count[10:0], v_count[9:0] raster position from the upstream counter
//   frame                       frame parity; flips the dither column pattern
//   kirby_visible/luma/feature  held ray-march sample
//   hsync, vsync                active-low syncs
//   de                          display enable
//   red, green, blue            RGB222 pixel
module kirby_pixel_out #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter bit          OUTLINE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        frame,
    input  logic        kirby_visible,
    input  logic [5:0]  kirby_luma,
    input  logic [2:0]  kirby_feature,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [1:0]  red,
    output logic [1:0]  green,
    output logic [1:0]  blue
);

    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam logic [HW-1:0] H_ACT_END = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    // Ordered-dither threshold matrix, indexed {row, col}.
    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] t;
        case ({row, col})
            4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
            4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
            4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
            4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  default: t = 4'd5;
        endcase
        return t;
    endfunction

    // base*(luma+1)/64; the product never exceeds 14 bits.
    function automatic logic [7:0] shade(input logic [7:0] base, input logic [5:0] luma);
        logic [13:0] prod;
        prod = 14'(base) * (14'(luma) + 14'd1);
        return prod[13:6];
    endfunction

    // Add dither offset with saturation, keep the top two bits.
    function automatic logic [1:0] quant(input logic [7:0] c, input logic [3:0] t);
        logic [8:0] sum;
        sum = {1'b0, c} + {3'b000, t, 2'b00};
        return sum[8] ? 2'b11 : sum[7:6];
    endfunction

    // Stage-1 input decode
    logic       act_c, hs_n_c, vs_n_c, outline_c;
    logic [7:0] base_r_c, base_g_c, base_b_c;
    logic       prev_vis;

    always_comb begin
        act_c     = (h_count < H_ACT_END) && (v_count < V_ACT_END);
        hs_n_c    = !((h_count >= HS_START) && (h_count < HS_END));
        vs_n_c    = !((v_count >= VS_START) && (v_count < VS_END));
        outline_c = OUTLINE_EN && act_c && (kirby_visible != prev_vis);
        base_r_c  = 8'hFF;
        base_g_c  = 8'h80;
        base_b_c  = 8'hB0;
        case (kirby_feature)
            3'd1: begin base_r_c = 8'h10; base_g_c = 8'h20; base_b_c = 8'h60; end
            3'd2: begin base_r_c = 8'hFF; base_g_c = 8'hFF; base_b_c = 8'hFF; end
            3'd3: begin base_r_c = 8'hFF; base_g_c = 8'h40; base_b_c = 8'h60; end
            3'd4: begin base_r_c = 8'hD0; base_g_c = 8'h00; base_b_c = 8'h20; end
            3'd5: begin base_r_c = 8'h80; base_g_c = 8'h00; base_b_c = 8'h20; end
            default: ;
        endcase
    end

    // Stage-1 registers
    logic       s1_act, s1_hs_n, s1_vs_n, s1_outline, s1_frame, s1_vis;
    logic [1:0] s1_h;
    logic [9:0] s1_v;
    logic [5:0] s1_luma;
    logic [7:0] s1_base_r, s1_base_g, s1_base_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_act     <= 1'b0;
            s1_hs_n    <= 1'b1;
            s1_vs_n    <= 1'b1;
            s1_outline <= 1'b0;
            s1_frame   <= 1'b0;
            s1_vis     <= 1'b0;
            s1_h       <= '0;
            s1_v       <= '0;
            s1_luma    <= '0;
            s1_base_r  <= '0;
            s1_base_g  <= '0;
            s1_base_b  <= '0;
            prev_vis   <= 1'b0;
        end else begin
            s1_act     <= act_c;
            s1_hs_n    <= hs_n_c;
            s1_vs_n    <= vs_n_c;
            s1_outline <= outline_c;
            s1_frame   <= frame;
            s1_vis     <= kirby_visible;
            s1_h       <= h_count[1:0];
            s1_v       <= v_count;
            s1_luma    <= kirby_luma;
            s1_base_r  <= base_r_c;
            s1_base_g  <= base_g_c;
            s1_base_b  <= base_b_c;
            // Line start clears the outline history; active pixels then track it.
            if (h_count == '0) begin
                prev_vis <= 1'b0;
            end else if (act_c) begin
                prev_vis <= kirby_visible;
            end
        end
    end

    // Stage-2 colour, dither and quantisation
    logic [3:0] bay_c;
    logic [7:0] c_r, c_g, c_b;
    logic [1:0] q_r, q_g, q_b;

    always_comb begin
        bay_c = bayer(s1_v[1:0], s1_h ^ {2{s1_frame}});
        if (s1_vis) begin
            c_r = shade(s1_base_r, s1_luma);
            c_g = shade(s1_base_g, s1_luma);
            c_b = shade(s1_base_b, s1_luma);
        end else begin
            c_r = 8'h20;
            c_g = 8'h40;
            c_b = 8'h60 + s1_v[9:2];
        end
        q_r = quant(c_r, bay_c);
        q_g = quant(c_g, bay_c);
        q_b = quant(c_b, bay_c);
    end

    // Output registers; blanking and outline pixels are black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hsync <= s1_hs_n;
            vsync <= s1_vs_n;
            de    <= s1_act;
            if (s1_act && !s1_outline) begin
                red   <= q_r;
                green <= q_g;
                blue  <= q_b;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_kirby_pixel_out.sv
// Bench for kirby_pixel_out: three instances (default, outline disabled,
// small raster) driven from one directed/random sequence and compared every
// clock against an arithmetic reference model.
module tb_kirby_pixel_out;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } pix_t;

    localparam pix_t RST = pix_t'(9'b110_000000);

    localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HT = 26;
    localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VT = 12;

    int bayer_tab[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    logic        clk, rst_n, frame, vis;
    logic [10:0] h, h_s;
    logic [9:0]  v, v_s;
    logic [5:0]  luma;
    logic [2:0]  feat;

    logic hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_s, vs_s, de_s;
    logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b, r_s, g_s, b_s;

    int checks = 0;
    int errors = 0;
    bit prev_a, prev_b, prev_s;
    pix_t qa[$], qb[$], qs[$];

    kirby_pixel_out dut_a (
        .clk(clk), .rst_n(rst_n), .h_count(h), .v_count(v), .frame(frame),
        .kirby_visible(vis), .kirby_luma(luma), .kirby_feature(feat),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .red(r_a), .green(g_a), .blue(b_a)
    );

    kirby_pixel_out #(.OUTLINE_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .h_count(h), .v_count(v), .frame(frame),
        .kirby_visible(vis), .kirby_luma(luma), .kirby_feature(feat),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .red(r_b), .green(g_b), .blue(b_b)
    );

    kirby_pixel_out #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .h_count(h_s), .v_count(v_s), .frame(frame),
        .kirby_visible(vis), .kirby_luma(luma), .kirby_feature(feat),
        .hsync(hs_s), .vsync(vs_s), .de(de_s), .red(r_s), .green(g_s), .blue(b_s)
    );

    always #5 clk = ~clk;

    // Reference pixel from the raster position and held sample.
    function automatic pix_t ref_pix(int hh, int vv, bit fr, bit vi, int lu, int fe,
                                     bit en, bit prev, int hv, int hf, int hsy,
                                     int vvis, int vf, int vsy);
        pix_t p;
        int base[3];
        int c, d, bay;
        logic [1:0] q[3];
        bit act, outl;
        act  = (hh < hv) && (vv < vvis);
        outl = en && act && (vi != prev);
        p.hs = !((hh >= hv + hf) && (hh < hv + hf + hsy));
        p.vs = !((vv >= vvis + vf) && (vv < vvis + vf + vsy));
        p.de = act;
        case (fe)
            1: base = '{16, 32, 96};
            2: base = '{255, 255, 255};
            3: base = '{255, 64, 96};
            4: base = '{208, 0, 32};
            5: base = '{128, 0, 32};
            default: base = '{255, 128, 176};
        endcase
        bay = bayer_tab[vv % 4][(hh % 4) ^ (fr ? 3 : 0)];
        for (int ch = 0; ch < 3; ch++) begin
            if (vi) c = base[ch] * (lu + 1) / 64;
            else    c = (ch == 0) ? 32 : (ch == 1) ? 64 : 96 + vv / 4;
            d = c + 4 * bay;
            if (d > 255) d = 255;
            q[ch] = (act && !outl) ? 2'(d / 64) : 2'd0;
        end
        p.r = q[0];
        p.g = q[1];
        p.b = q[2];
        return p;
    endfunction

    function automatic bit upd_prev(bit prev, int hh, int vv, bit vi, int hv, int vvis);
        if (hh == 0) return 1'b0;
        if ((hh < hv) && (vv < vvis)) return vi;
        return prev;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_in();
        h     = 11'($urandom_range(0, 799));
        v     = 10'($urandom_range(0, 524));
        frame = 1'($urandom_range(0, 1));
        vis   = 1'($urandom_range(0, 1));
        luma  = 6'($urandom_range(0, 63));
        feat  = 3'($urandom_range(0, 7));
    endtask

    task automatic set_in(int hh, int vv, bit fr, bit vi, int lu, int fe);
        h = 11'(hh); v = 10'(vv); frame = fr; vis = vi; luma = 6'(lu); feat = 3'(fe);
    endtask

    // One clock: model the sample taken at this edge, check the outputs due now.
    task automatic cycle();
        pix_t ea, eb, es;
        @(posedge clk);
        qa.push_back(ref_pix(int'(h), int'(v), frame, vis, int'(luma), int'(feat), 1'b1, prev_a,
                             640, 16, 96, 480, 10, 2));
        qb.push_back(ref_pix(int'(h), int'(v), frame, vis, int'(luma), int'(feat), 1'b0, prev_b,
                             640, 16, 96, 480, 10, 2));
        qs.push_back(ref_pix(int'(h_s), int'(v_s), frame, vis, int'(luma), int'(feat), 1'b1, prev_s,
                             S_HV, S_HF, S_HS, S_VV, S_VF, S_VS));
        prev_a = upd_prev(prev_a, int'(h), int'(v), vis, 640, 480);
        prev_b = upd_prev(prev_b, int'(h), int'(v), vis, 640, 480);
        prev_s = upd_prev(prev_s, int'(h_s), int'(v_s), vis, S_HV, S_VV);
        ea = qa.pop_front();
        eb = qb.pop_front();
        es = qs.pop_front();
        #1;
        chk("pix_a", 32'({hs_a, vs_a, de_a, r_a, g_a, b_a}), 32'(ea));
        chk("pix_b", 32'({hs_b, vs_b, de_b, r_b, g_b, b_b}), 32'(eb));
        chk("pix_s", 32'({hs_s, vs_s, de_s, r_s, g_s, b_s}), 32'(es));
        if (int'(h_s) == S_HT - 1) begin
            h_s = '0;
            v_s = (int'(v_s) == S_VT - 1) ? 10'd0 : v_s + 10'd1;
        end else begin
            h_s = h_s + 11'd1;
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_a"}, 32'({hs_a, vs_a, de_a, r_a, g_a, b_a}), 32'(RST));
        chk({tag, "_b"}, 32'({hs_b, vs_b, de_b, r_b, g_b, b_b}), 32'(RST));
        chk({tag, "_s"}, 32'({hs_s, vs_s, de_s, r_s, g_s, b_s}), 32'(RST));
    endtask

    // Async reset from mid-cycle, held n clocks with random inputs, released on a falling edge.
    task automatic do_reset(int n);
        rst_n = 1'b0;
        #1;
        chk_rst("rst_async");
        repeat (n) begin
            rand_in();
            @(posedge clk);
            #1;
            chk_rst("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete(); qb.delete(); qs.delete();
        qa.push_back(RST); qb.push_back(RST); qs.push_back(RST);
        prev_a = 1'b0; prev_b = 1'b0; prev_s = 1'b0;
        h_s = '0; v_s = '0;
    endtask

    initial begin
        int cnt_hs, cnt_vs, cnt_de;
        clk = 1'b0;
        rst_n = 1'b1;
        h_s = '0; v_s = '0;
        rand_in();
        #2;
        do_reset(4);

        // Outputs follow h/v two clocks after release.
        repeat (6) begin rand_in(); cycle(); end

        // Picture pixel, previous pixel also visible: palette 0 at full luma, bayer 0.
        set_in(639, 0, 1'b0, 1'b1, 63, 0); cycle();
        set_in(0, 0, 1'b0, 1'b1, 63, 0);   cycle();
        set_in(700, 0, 1'b0, 1'b0, 0, 0);  cycle();
        chk("t3_rgb", 32'({de_a, r_a, g_a, b_a}), 32'(7'b1_11_10_10));

        // Bayer 15 row: white saturates, dark base dithers to zero.
        set_in(639, 2, 1'b0, 1'b1, 63, 2); cycle();
        set_in(0, 3, 1'b0, 1'b1, 63, 2);   cycle();
        set_in(700, 3, 1'b0, 1'b0, 0, 0);  cycle();
        chk("t4_sat", 32'({de_a, r_a, g_a, b_a}), 32'(7'b1_11_11_11));
        set_in(639, 2, 1'b0, 1'b1, 0, 0);  cycle();
        set_in(0, 3, 1'b0, 1'b1, 0, 0);    cycle();
        set_in(700, 3, 1'b0, 1'b0, 0, 0);  cycle();
        chk("t4_dark", 32'({de_a, r_a, g_a, b_a}), 32'(7'b1_00_00_00));

        // Sky gradient at v=200 with bayer 8.
        set_in(0, 200, 1'b0, 1'b0, 0, 0);  cycle();
        set_in(1, 200, 1'b0, 1'b0, 0, 0);  cycle();
        set_in(700, 200, 1'b0, 1'b0, 0, 0); cycle();
        chk("t6_sky", 32'({de_a, r_a, g_a, b_a}), 32'(7'b1_01_01_10));

        // Silhouette edge at h=100, with and without the outline.
        for (int i = 90; i <= 112; i++) begin
            set_in(i, 10, 1'b1, i >= 100, 63, 2);
            cycle();
            if (i == 101) begin
                chk("t5_edge_on",  32'({de_a, r_a, g_a, b_a}), 32'(7'b1_00_00_00));
                chk("t5_edge_off", 32'({de_b, r_b, g_b, b_b}), 32'(7'b1_11_11_11));
            end
            if (i == 102) chk("t5_after", 32'({de_a, r_a, g_a, b_a}), 32'(7'b1_11_11_11));
        end

        // Full line at v=0: hsync low for exactly 96 clocks.
        cnt_hs = 0;
        for (int i = 0; i <= 800; i++) begin
            set_in((i < 800) ? i : 0, 0, 1'(i / 4), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
            cycle();
            if (i >= 1 && !hs_a) cnt_hs++;
        end
        chk("line_hs_low", 32'(cnt_hs), 32'(96));

        // Column h=0 down a frame: vsync low 2 lines, de on 480 lines.
        cnt_vs = 0; cnt_de = 0;
        for (int i = 0; i <= 525; i++) begin
            set_in(0, (i < 525) ? i : 0, 1'b0, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
            cycle();
            if (i >= 1 && !vs_a) cnt_vs++;
            if (i >= 1 && de_a) cnt_de++;
        end
        chk("col_vs_low", 32'(cnt_vs), 32'(2));
        chk("col_de",     32'(cnt_de), 32'(480));

        // Random runs of consecutive pixels with sticky visibility; one reset mid-line.
        for (int seg = 0; seg < 60; seg++) begin
            int hh, vv;
            hh = int'($urandom_range(0, 799));
            vv = int'($urandom_range(0, 524));
            set_in(hh, vv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
            for (int p = 0; p < 40; p++) begin
                h = 11'(hh);
                v = 10'(vv);
                luma = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 5) == 0) vis = ~vis;
                if ($urandom_range(0, 9) == 0) feat = 3'($urandom_range(0, 7));
                cycle();
                if (seg == 30 && p == 20) do_reset(3);
                hh = (hh == 799) ? 0 : hh + 1;
                if (hh == 0) vv = (vv == 524) ? 0 : vv + 1;
            end
        end

        // Small raster: one whole frame of sync/enable counts.
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
        for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
            rand_in();
            cycle();
            if (i >= S_HT * S_VT) begin
                if (!hs_s) cnt_hs++;
                if (!vs_s) cnt_vs++;
                if (de_s)  cnt_de++;
            end
        end
        chk("frame_de",     32'(cnt_de), 32'(S_HV * S_VV));
        chk("frame_hs_low", 32'(cnt_hs), 32'(S_HS * S_VT));
        chk("frame_vs_low", 32'(cnt_vs), 32'(S_VS * S_HT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
